step_pulse_decoder: RTL and testbench

- Receive-side counterpart of the step-pulse generator path.
- Samples an external step/dir pair (from a driver board, or looped back from the generator's step output), synchronizes and edge-detects it, and accumulates signed axis position.
- Counts steps against an armed expected count, and reports step period plus move completion with a finish pulse.
- Used for closed-loop checking of commanded moves and for position tracking on externally driven axes.

---
 rtl/step_pulse_decoder.sv | 248 ++++++++++++++++++++++++
 tb/tb_step_pulse_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_decoder.sv
// step_pulse_decoder
//
// Receive side of a step/dir axis link. The block synchronises an external
// step/dir pair, picks out one accepted step per step pulse and keeps a
// signed position that wraps. It also counts steps against an armed target,
// measures the clk period between the last two accepted steps, and reports
// the end of a move with a finish pulse or a timeout pulse.
//
// Optional build macro: STEP_GLITCH_FILTER_EN
//   When defined, a step is accepted only after the synchronised step input
//   has been high for MIN_HIGH consecutive cycles after a low. Shorter highs
//   are ignored. When undefined, every synchronised rising edge is a step.
//
// Ports:
//   clk          in   system clock; everything runs on this one clock
//   reset        in   synchronous, active-high reset
//   step_in      in   asynchronous step input; a rising edge is one step
//   dir_in       in   asynchronous direction; 1 = +1, 0 = -1
//   arm          in   one-cycle pulse; latches expected and starts a move
//   expected     in   [30:0] number of steps expected for the move
//   clear_pos    in   one-cycle pulse; zeroes position before this cycle's step
//   position     out  [POS_W-1:0] signed accumulated position
//   step_count   out  [30:0] steps accepted since the last arm
//   period       out  [PER_W-1:0] clk cycles between the last two steps
//   period_valid out  one-cycle pulse when period updates
//   busy         out  high while a move is being tracked
//   finish       out  one-cycle pulse when step_count reaches the target
//   timeout      out  one-cycle pulse when a tracked move goes idle too long
//   overrun      out  sticky; a step arrived after the move had finished

module step_pulse_decoder #(
  parameter int POS_W        = 32,
  parameter int PER_W        = 32,
  parameter int IDLE_TIMEOUT = 1000000,
  parameter int MIN_HIGH     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    arm,
  input  logic [30:0]             expected,
  input  logic                    clear_pos,
  output logic signed [POS_W-1:0] position,
  output logic [30:0]             step_count,
  output logic [PER_W-1:0]        period,
  output logic                    period_valid,
  output logic                    busy,
  output logic                    finish,
  output logic                    timeout,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  localparam int                IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [30:0]       COUNT_MAX = '1;

  state_t state, state_next;

  logic step_s1, step_s2;
  logic dir_s1, dir_s2;
  logic accept;

  logic [30:0]             target, target_next;
  logic [30:0]             count_next;
  logic [IDLE_W-1:0]       idle_cnt, idle_next;
  logic [PER_W-1:0]        per_cnt, per_cnt_next;
  logic [PER_W-1:0]        period_next;
  logic                    pv_next;
  logic                    have_prev, have_prev_next;
  logic signed [POS_W-1:0] pos_base, pos_next;
  logic                    finish_next, timeout_next, overrun_next;

  // Two-flop synchronisers for both inputs. Direction travels through the
  // same depth as step, so the dir value seen with an accept belongs to it.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      dir_s1  <= 1'b0;
      dir_s2  <= 1'b0;
    end else begin
      step_s1 <= step_in;
      step_s2 <= step_s1;
      dir_s1  <= dir_in;
      dir_s2  <= dir_s1;
    end
  end

`ifdef STEP_GLITCH_FILTER_EN
  localparam int               RUN_W   = $clog2(MIN_HIGH + 1);
  localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(MIN_HIGH - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_HIGH);

  logic [RUN_W-1:0] high_run;

  // high_run counts how many cycles in a row the synced step has already
  // been high. It saturates so a long high fires exactly one accept.
  always_ff @(posedge clk) begin
    if (reset || !step_s2) begin
      high_run <= '0;
    end else if (high_run != RUN_MAX) begin
      high_run <= high_run + RUN_W'(1);
    end
  end

  assign accept = step_s2 && (high_run == RUN_HIT);
`else
  localparam int unused_min_high = MIN_HIGH;

  logic step_s3;

  // Third step flop: a step is accepted on the synced rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_s3 <= 1'b0;
    end else begin
      step_s3 <= step_s2;
    end
  end

  assign accept = step_s2 && !step_s3;
`endif

  // Position and period datapath. Position follows every accepted step in
  // every state. A coincident clear_pos zeroes first, then the step is
  // applied. An arm on an accept cycle makes that step the first of a new
  // move, so it only re-arms the previous-edge flag and reports no period.
  always_comb begin
    pos_base = clear_pos ? '0 : position;
    pos_next = pos_base;
    if (accept) begin
      pos_next = dir_s2 ? pos_base + POS_W'(1) : pos_base - POS_W'(1);
    end

    per_cnt_next = (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);
    period_next  = period;
    pv_next      = 1'b0;
    if (accept) begin
      per_cnt_next = PER_W'(1);
      if (have_prev && !arm) begin
        period_next = per_cnt;
        pv_next     = 1'b1;
      end
    end

    have_prev_next = have_prev;
    if (arm) begin
      have_prev_next = accept;
    end else if (accept) begin
      have_prev_next = 1'b1;
    end
  end

  // Move FSM: next state, step_count, target, idle timer and the
  // finish/timeout/overrun outputs. arm beats everything else. Finish
  // beats timeout, and any accept also restarts the idle timer, so the
  // two pulses can never coincide.
  always_comb begin
    state_next   = state;
    count_next   = step_count;
    target_next  = target;
    overrun_next = overrun;
    finish_next  = 1'b0;
    timeout_next = 1'b0;
    idle_next    = '0;

    if (arm) begin
      target_next  = expected;
      count_next   = accept ? 31'd1 : 31'd0;
      overrun_next = 1'b0;
      if (expected == 31'd0 || (accept && expected == 31'd1)) begin
        state_next  = DONE;
        finish_next = 1'b1;
      end else begin
        state_next = TRACK;
      end
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        TRACK: begin
          if (accept) begin
            count_next = step_count + 31'd1;
            if (count_next == target) begin
              finish_next = 1'b1;
              state_next  = DONE;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            timeout_next = 1'b1;
            state_next   = DONE;
          end else begin
            idle_next = idle_cnt + IDLE_W'(1);
          end
        end
        DONE: begin
          if (accept) begin
            overrun_next = 1'b1;
            if (step_count != COUNT_MAX) begin
              count_next = step_count + 31'd1;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and output registers. Reset clears everything, which also drops
  // any move in flight without a finish or timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      position     <= '0;
      step_count   <= '0;
      target       <= '0;
      idle_cnt     <= '0;
      per_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      have_prev    <= 1'b0;
      finish       <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_next;
      position     <= pos_next;
      step_count   <= count_next;
      target       <= target_next;
      idle_cnt     <= idle_next;
      per_cnt      <= per_cnt_next;
      period       <= period_next;
      period_valid <= pv_next;
      have_prev    <= have_prev_next;
      finish       <= finish_next;
      timeout      <= timeout_next;
      overrun      <= overrun_next;
    end
  end

  assign busy = (state == TRACK);

endmodule

// File: tb/tb_step_pulse_decoder.sv
// tb_step_pulse_decoder
//
// Directed bench for step_pulse_decoder (POS_W=8, IDLE_TIMEOUT=50,
// MIN_HIGH=3). A behavioural model keyed on clock-edge indices predicts
// every output, and the outputs are compared on every falling edge. A set of
// hand-computed literal checks pins the model at the interesting points.
// Honours STEP_GLITCH_FILTER_EN in the same way the design does.

module tb_step_pulse_decoder;

  localparam int POS_W        = 8;
  localparam int PER_W        = 32;
  localparam int IDLE_TIMEOUT = 50;
  localparam int MIN_HIGH     = 3;
`ifdef STEP_GLITCH_FILTER_EN
  localparam int M = MIN_HIGH;
`else
  localparam int M = 1;
`endif
  localparam int ACC_LAT = 2 + M;
  localparam int HIST    = 8192;
  localparam int MIDLE   = 0;
  localparam int MTRACK  = 1;
  localparam int MDONE   = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    step_in = 1'b0;
  logic                    dir_in = 1'b0;
  logic                    arm = 1'b0;
  logic [30:0]             expected = '0;
  logic                    clear_pos = 1'b0;
  logic signed [POS_W-1:0] position;
  logic [30:0]             step_count;
  logic [PER_W-1:0]        period;
  logic                    period_valid;
  logic                    busy;
  logic                    finish;
  logic                    timeout;
  logic                    overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  step_pulse_decoder #(
    .POS_W(POS_W), .PER_W(PER_W), .IDLE_TIMEOUT(IDLE_TIMEOUT), .MIN_HIGH(MIN_HIGH)
  ) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .arm(arm), .expected(expected), .clear_pos(clear_pos),
    .position(position), .step_count(step_count), .period(period),
    .period_valid(period_valid), .busy(busy), .finish(finish),
    .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Model state: what each output must be after the latest rising edge.
  bit                      samp [0:HIST-1];
  bit                      dsamp[0:HIST-1];
  bit                      m_ready = 1'b0;
  int                      m_mode = MIDLE;
  logic signed [POS_W-1:0] m_pos = '0;
  logic [30:0]             m_count = '0;
  logic [30:0]             m_target = '0;
  logic [31:0]             m_period = '0;
  bit                      m_pv, m_fin, m_to, m_ovr, m_have_prev;
  int                      m_last_acc = 0;
  int                      m_last_act = 0;

  // Event bookkeeping for the literal checks.
  int  fin_count = 0, to_count = 0, pv_count = 0;
  int  fin_edge = 0, to_edge = 0;
  bit  fin_busy = 1'b0;
  int  last_rise = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at edge %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Drive inputs for `hold` cycles; arm and clear_pos last one cycle only.
  task automatic applyStimulus(input logic s, input logic d, input logic a,
                               input logic [30:0] e, input logic c, input int hold);
    if (s && !step_in) last_rise = cyc;
    step_in = s; dir_in = d; arm = a; expected = e; clear_pos = c;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      arm = 1'b0;
      clear_pos = 1'b0;
    end
  endtask

  task automatic stepPulse(input logic d, input int hi, input int lo);
    applyStimulus(1'b1, d, 1'b0, 31'd0, 1'b0, hi);
    applyStimulus(1'b0, d, 1'b0, 31'd0, 1'b0, lo);
  endtask

  // Behavioural model. A step takes effect at edge k when the step input
  // sampled at edges k-2 back to k-1-M was high and the sample before that
  // was low; its direction is dir_in sampled at edge k-2.
  always @(posedge clk) begin : model
    int run;
    bit acc;
    bit d;
    cyc = cyc + 1;
    if (cyc >= HIST) begin
      $display("[TB] FAIL history: edge %0d exceeds bench capacity %0d", cyc, HIST);
      $fatal(1, "[TB] bench history overflow");
    end
    samp[cyc]  = reset ? 1'b0 : step_in;
    dsamp[cyc] = reset ? 1'b0 : dir_in;
    run = 0;
    for (int j = cyc - 2; j >= 0 && run <= M; j--) begin
      if (samp[j]) run++;
      else break;
    end
    acc = (run == M);
    d   = (cyc >= 2) ? dsamp[cyc-2] : 1'b0;
    m_pv = 1'b0; m_fin = 1'b0; m_to = 1'b0;
    if (reset) begin
      m_ready = 1'b1;
      m_mode = MIDLE; m_pos = '0; m_count = '0; m_target = '0; m_period = '0;
      m_ovr = 1'b0; m_have_prev = 1'b0;
    end else begin
      if (clear_pos) m_pos = '0;
      if (acc) m_pos = d ? m_pos + 8'sd1 : m_pos - 8'sd1;
      if (arm) begin
        m_target = expected;
        m_count = acc ? 31'd1 : 31'd0;
        m_ovr = 1'b0;
        m_have_prev = acc;
        m_last_act = cyc;
        if (acc) m_last_acc = cyc;
        if (expected == 0 || (acc && expected == 1)) begin
          m_mode = MDONE; m_fin = 1'b1;
        end else begin
          m_mode = MTRACK;
        end
      end else begin
        if (acc) begin
          if (m_have_prev) begin
            m_period = 32'(cyc - m_last_acc);
            m_pv = 1'b1;
          end
          m_have_prev = 1'b1;
          m_last_acc = cyc;
        end
        if (m_mode == MTRACK) begin
          if (acc) begin
            m_count = m_count + 31'd1;
            m_last_act = cyc;
            if (m_count == m_target) begin
              m_fin = 1'b1; m_mode = MDONE;
            end
          end else if (cyc - m_last_act == IDLE_TIMEOUT) begin
            m_to = 1'b1; m_mode = MDONE;
          end
        end else if (m_mode == MDONE && acc) begin
          m_ovr = 1'b1;
          if (m_count != 31'h7fffffff) m_count = m_count + 31'd1;
        end
      end
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (m_ready) begin
      checkOutput("position", 32'($unsigned(position)), 32'($unsigned(m_pos)));
      checkOutput("step_count", 32'(step_count), 32'(m_count));
      checkOutput("period", period, m_period);
      checkOutput("period_valid", 32'(period_valid), 32'(m_pv));
      checkOutput("busy", 32'(busy), 32'(m_mode == MTRACK));
      checkOutput("finish", 32'(finish), 32'(m_fin));
      checkOutput("timeout", 32'(timeout), 32'(m_to));
      checkOutput("overrun", 32'(overrun), 32'(m_ovr));
      if (finish) begin fin_count++; fin_edge = cyc; fin_busy = busy; end
      if (timeout) begin to_count++; to_edge = cyc; end
      if (period_valid) pv_count++;
    end
  end

  task automatic clearEvents();
    fin_count = 0; to_count = 0; pv_count = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: run did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int rise4;
    int rise_to;
    int glitch_pos;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 31'd0, 1'b0, 3);
    @(negedge clk);
    checkOutput("reset position", 32'($unsigned(position)), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 31'd0, 1'b0, 2);

    // Position tracking while idle
    for (int i = 0; i < 5; i++) stepPulse(1'b1, 4, 4);
    for (int i = 0; i < 2; i++) stepPulse(1'b0, 4, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 31'd0, 1'b0, 4);
    @(negedge clk);
    checkOutput("idle position", 32'($unsigned(position)), 32'd3);
    checkOutput("idle step_count", 32'(step_count), 32'd0);

    // Normal move: 4 steps, 10 clk apart
    clearEvents();
    applyStimulus(1'b0, 1'b1, 1'b1, 31'd4, 1'b0, 2);
    rise4 = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 31'd0, 1'b0, 4);
      if (i == 3) rise4 = last_rise;
      applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b0, 6);
    end
    @(negedge clk);
    checkOutput("move finish pulses", 32'(fin_count), 32'd1);
    checkOutput("move finish latency", 32'(fin_edge - rise4), 32'(ACC_LAT));
    checkOutput("busy at finish", 32'(fin_busy), 32'd0);
    checkOutput("move step_count", 32'(step_count), 32'd4);
    checkOutput("move period", period, 32'd10);
    checkOutput("move period_valid pulses", 32'(pv_count), 32'd3);

    // Overrun after finish, cleared by the next arm
    stepPulse(1'b1, 4, 6);
    @(negedge clk);
    checkOutput("overrun set", 32'(overrun), 32'd1);
    checkOutput("overrun step_count", 32'(step_count), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 31'd3, 1'b0, 1);
    @(negedge clk);
    checkOutput("overrun cleared by arm", 32'(overrun), 32'd0);
    checkOutput("busy after arm", 32'(busy), 32'd1);

    // Timeout: one step then silence
    clearEvents();
    stepPulse(1'b1, 4, 4);
    rise_to = last_rise;
    applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b0, 60);
    @(negedge clk);
    checkOutput("timeout pulses", 32'(to_count), 32'd1);
    checkOutput("timeout latency", 32'(to_edge - rise_to), 32'(ACC_LAT + IDLE_TIMEOUT));
    checkOutput("timeout step_count", 32'(step_count), 32'd1);
    checkOutput("timeout no finish", 32'(fin_count), 32'd0);

    // arm with expected = 0 finishes on the next cycle
    applyStimulus(1'b0, 1'b1, 1'b1, 31'd0, 1'b0, 1);
    @(negedge clk);
    checkOutput("arm0 finish", 32'(finish), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b0, 1);
    @(negedge clk);
    checkOutput("arm0 finish one cycle", 32'(finish), 32'd0);

    // clear_pos coincident with a dir=0 accept
    applyStimulus(1'b1, 1'b0, 1'b0, 31'd0, 1'b0, 1 + M);
    applyStimulus(1'b1, 1'b0, 1'b0, 31'd0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 31'd0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 31'd0, 1'b0, 6);
    @(negedge clk);
    checkOutput("clear_pos with step", 32'($unsigned(position)), 32'hff);

    // arm during TRACK restarts the move with no finish
    clearEvents();
    applyStimulus(1'b0, 1'b1, 1'b1, 31'd2, 1'b0, 2);
    stepPulse(1'b1, 4, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 31'd2, 1'b0, 2);
    @(negedge clk);
    checkOutput("restart step_count", 32'(step_count), 32'd0);
    checkOutput("restart busy", 32'(busy), 32'd1);
    checkOutput("restart no finish", 32'(fin_count), 32'd0);

    // arm in the same cycle as an accept: the step counts into the new move
    applyStimulus(1'b1, 1'b1, 1'b0, 31'd0, 1'b0, 1 + M);
    applyStimulus(1'b1, 1'b1, 1'b1, 31'd5, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 31'd0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b0, 6);
    @(negedge clk);
    checkOutput("arm+accept step_count", 32'(step_count), 32'd1);

    // Reset mid-move aborts silently
    clearEvents();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b0, 2);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b0, 60);
    @(negedge clk);
    checkOutput("reset abort busy", 32'(busy), 32'd0);
    checkOutput("reset abort events", 32'(fin_count + to_count), 32'd0);

    // Short highs: ignored by the filter, counted without it
    glitch_pos = (M <= 2) ? 1 : 0;
    stepPulse(1'b1, 2, 6);
    @(negedge clk);
    checkOutput("2-cycle high pulse", 32'($unsigned(position)), 32'(glitch_pos));
    stepPulse(1'b1, 3, 6);
    @(negedge clk);
    checkOutput("3-cycle high pulse", 32'($unsigned(position)), 32'(glitch_pos + 1));

    // Wrap at the top of an 8-bit position
    applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b1, 2);
    for (int i = 0; i < 127; i++) stepPulse(1'b1, 3, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b0, 4);
    @(negedge clk);
    checkOutput("position max", 32'($unsigned(position)), 32'h7f);
    stepPulse(1'b1, 3, 6);
    @(negedge clk);
    checkOutput("position wrap", 32'($unsigned(position)), 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
